// File: rtl/clb_cfg_pkg.sv
// Shared definitions for the CLB slice configuration loader.
// Holds the chain-length derivation (LUT config size and total slice config bits,
// including the carry-chain enable bit) and the loader FSM state encoding.
package clb_cfg_pkg;

    // Config bits for one LUT with 2**s_xx_base inputs combinations plus one mode bit.
    function automatic int unsigned cfg_size(input int unsigned s_xx_base);
        return (32'd1 << s_xx_base) + 32'd1;
    endfunction

    // Two config groups per LUT, plus the slice carry-chain enable bit.
    function automatic int unsigned chain_len(input int unsigned s_xx_base,
                                              input int unsigned num_luts);
        return num_luts * 32'd2 * cfg_size(s_xx_base) + 32'd1;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } cfg_state_t;

endpackage

// File: rtl/cfg_piso.sv
// Parallel-in serial-out shift register feeding the slice config chain.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset, clears the register
//   load  - capture din (has priority over shift)
//   shift - shift right by one, zero fill at the MSB
//   din   - parallel word
//   dout  - register bit 0, the next serial bit
module cfg_piso
    import clb_cfg_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= sr >> 1;
        end
    end

    assign dout = sr[0];

endmodule

// File: rtl/slice_config_loader.sv
// Loads a CLB slice configuration chain from host words.
// Host words are accepted one at a time and shifted out LSB first onto cfg_bit
// with cfg_en high; the final word is truncated so exactly CHAIN_LEN bits are sent.
// Ports:
//   cclk       - configuration clock
//   rst        - synchronous active-high reset
//   start      - begin a load (honoured in IDLE and DONE)
//   abort      - cancel a load (LOAD, SHIFT, DONE -> IDLE)
//   word_in    - host word, LSB shifted first
//   word_valid - word_in valid
//   word_ready - loader accepts word_in this cycle
//   cfg_bit    - serial config data to the slice
//   cfg_en     - slice config shift enable
//   busy       - load in progress
//   done       - all CHAIN_LEN bits delivered
//   bit_count  - bits shifted in the current load
module slice_config_loader
    import clb_cfg_pkg::*;
#(
    parameter  int unsigned S_XX_BASE = 4,
    parameter  int unsigned NUM_LUTS  = 4,
    parameter  int unsigned WORD_W    = 32,
    localparam int unsigned CHAIN_LEN = chain_len(S_XX_BASE, NUM_LUTS),
    localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              cclk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cfg_bit,
    output logic              cfg_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int unsigned     LEFT_W      = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);

    cfg_state_t        state;
    logic [LEFT_W-1:0] word_left;
    logic [LEFT_W-1:0] word_take;
    int unsigned       remaining;
    logic              piso_load;
    logic              piso_shift;
    logic              piso_bit;

    // Bits to take from the word being accepted: a full word, or the chain remainder.
    always_comb begin
        remaining = CHAIN_LEN - 32'(bit_count);
        word_take = LEFT_W'(WORD_W);
        if (remaining < WORD_W) begin
            word_take = LEFT_W'(remaining);
        end
    end

    // Abort wins over a handshake or a shift in the same cycle.
    assign piso_load  = (state == LOAD) && word_valid && !abort;
    assign piso_shift = (state == SHIFT) && !abort;

    always_ff @(posedge cclk) begin
        if (rst) begin
            state     <= IDLE;
            bit_count <= '0;
            word_left <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        bit_count <= '0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (word_valid) begin
                        word_left <= word_take;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        bit_count <= bit_count + 1'b1;
                        word_left <= word_left - 1'b1;
                        if (bit_count == CHAIN_LEN_C - 1'b1) begin
                            state <= DONE;
                        end else if (word_left == LEFT_W'(1)) begin
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (start) begin
                        state     <= LOAD;
                        bit_count <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    cfg_piso #(
        .WIDTH (WORD_W)
    ) u_piso (
        .clk   (cclk),
        .rst   (rst),
        .load  (piso_load),
        .shift (piso_shift),
        .din   (word_in),
        .dout  (piso_bit)
    );

    // Outputs decode directly from the state register.
    assign word_ready = (state == LOAD);
    assign cfg_en     = (state == SHIFT);
    assign busy       = (state == LOAD) || (state == SHIFT);
    assign done       = (state == DONE);
    assign cfg_bit    = cfg_en & piso_bit;

endmodule

// File: tb/tb_slice_config_loader.sv
// Testbench for slice_config_loader: random host words, reference stream built from
// the concatenated words LSB-first truncated to the chain length.
module tb_slice_config_loader;

    localparam int S_XX_BASE = 4;
    localparam int NUM_LUTS  = 4;
    localparam int WORD_W    = 32;
    localparam int CHAIN_LEN = NUM_LUTS * 2 * ((1 << S_XX_BASE) + 1) + 1;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
    localparam int N_WORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = CHAIN_LEN - (N_WORDS - 1) * WORD_W;

    localparam int NUM_LUTS2  = 2;
    localparam int WORD_W2    = 8;
    localparam int CHAIN2     = NUM_LUTS2 * 2 * ((1 << S_XX_BASE) + 1) + 1;
    localparam int CNT2_W     = $clog2(CHAIN2 + 1);
    localparam int N_WORDS2   = (CHAIN2 + WORD_W2 - 1) / WORD_W2;
    localparam int LAST_BITS2 = CHAIN2 - (N_WORDS2 - 1) * WORD_W2;

    logic              cclk = 1'b0;
    logic              rst, start, abort, word_valid;
    logic [WORD_W-1:0] word_in;
    logic              word_ready, cfg_bit, cfg_en, busy, done;
    logic [CNT_W-1:0]  bit_count;

    logic               s_start, s_abort, s_word_valid;
    logic [WORD_W2-1:0] s_word_in;
    logic               s_word_ready, s_cfg_bit, s_cfg_en, s_busy, s_done;
    logic [CNT2_W-1:0]  s_bit_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WORD_W-1:0] words[$];
    logic              stream[$];
    int                idx, stall_cnt, load_cycles, gap_bad, elapsed;
    logic              prev_ready, prev_valid;

    always #5 cclk = ~cclk;

    slice_config_loader #(
        .S_XX_BASE (S_XX_BASE),
        .NUM_LUTS  (NUM_LUTS),
        .WORD_W    (WORD_W)
    ) dut (
        .cclk       (cclk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .cfg_bit    (cfg_bit),
        .cfg_en     (cfg_en),
        .busy       (busy),
        .done       (done),
        .bit_count  (bit_count)
    );

    slice_config_loader #(
        .S_XX_BASE (S_XX_BASE),
        .NUM_LUTS  (NUM_LUTS2),
        .WORD_W    (WORD_W2)
    ) dut2 (
        .cclk       (cclk),
        .rst        (rst),
        .start      (s_start),
        .abort      (s_abort),
        .word_in    (s_word_in),
        .word_valid (s_word_valid),
        .word_ready (s_word_ready),
        .cfg_bit    (s_cfg_bit),
        .cfg_en     (s_cfg_en),
        .busy       (s_busy),
        .done       (s_done),
        .bit_count  (s_bit_count)
    );

    // Everything the slice would see: one bit per cfg_en cycle.
    always @(negedge cclk) begin
        if (cfg_en === 1'b1) stream.push_back(cfg_bit);
    end

    // Reference: bit i of the chain is bit (i mod WORD_W) of host word i / WORD_W.
    function automatic int stream_errors();
        int e = 0;
        for (int i = 0; i < stream.size() && i < CHAIN_LEN; i++) begin
            if (stream[i] !== words[i / WORD_W][i % WORD_W]) e++;
        end
        return e;
    endfunction

    task automatic do_start();
        @(negedge cclk);
        words.delete();
        for (int i = 0; i < N_WORDS + 1; i++) words.push_back($urandom);
        stream.delete();
        idx = 0; stall_cnt = 0; prev_ready = 1'b0; prev_valid = 1'b0;
        word_valid = 1'b0;
        start = 1'b1;
        @(negedge cclk);
        start = 1'b0;
    endtask

    // Host model: stall == 0 keeps the next word valid continuously; otherwise it
    // waits `stall` LOAD cycles before raising valid. Stops at done, at a SHIFT cycle
    // with bit_count == stop_bit, or after budget cycles.
    task automatic feed_until(input int stall, input int stop_bit, input int budget);
        int cyc = 0;
        bit running = 1'b1;
        bit timed_out = 1'b0;
        load_cycles = 0; gap_bad = 0;
        while (running) begin
            if (prev_ready && prev_valid) begin
                idx++;
                stall_cnt = 0;
            end
            if (done === 1'b1 ||
                (stop_bit >= 0 && cfg_en === 1'b1 && int'(bit_count) == stop_bit)) begin
                running = 1'b0;
            end else if (cyc >= budget) begin
                timed_out = 1'b1;
                running = 1'b0;
            end else begin
                if (word_ready === 1'b1) load_cycles++;
                if (busy === 1'b1 && cfg_en !== 1'b1 && word_ready !== 1'b1) gap_bad++;
                if (stall == 0) begin
                    word_valid = (idx < words.size());
                end else if (word_ready === 1'b1 && stall_cnt >= stall) begin
                    word_valid = 1'b1;
                end else begin
                    word_valid = 1'b0;
                    if (word_ready === 1'b1) stall_cnt++;
                end
                if (idx < words.size()) word_in = words[idx];
                prev_ready = word_ready;
                prev_valid = word_valid;
                @(negedge cclk);
                cyc++;
            end
        end
        word_valid = 1'b0;
        prev_valid = 1'b0;
        elapsed = cyc;
        n_tests++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL feed_timeout: ran %0d cycles, budget %0d", cyc, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b1; word_valid = 1'b1; word_in = $urandom;
        s_start = 1'b1; s_abort = 1'b0; s_word_valid = 1'b1; s_word_in = 8'hA5;
        repeat (3) @(negedge cclk);
        n_tests++;
        if ({word_ready, cfg_en, cfg_bit, busy, done} !== 5'b0 || bit_count !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy/en/bit/busy/done=%b count=%0d, want 0",
                     {word_ready, cfg_en, cfg_bit, busy, done}, bit_count);
        end
        n_tests++;
        if ({s_word_ready, s_cfg_en, s_busy, s_done} !== 4'b0 || s_bit_count !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_small: flags=%b count=%0d, want 0",
                     {s_word_ready, s_cfg_en, s_busy, s_done}, s_bit_count);
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0; word_valid = 1'b0;
        s_start = 1'b0; s_word_valid = 1'b0;
        repeat (2) @(negedge cclk);
        n_tests++;
        if (busy !== 1'b0 || word_ready !== 1'b0 || bit_count !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b ready=%b count=%0d, want 0 0 0",
                     busy, word_ready, bit_count);
        end
    endtask

    task automatic test_full_load();
        do_start();
        n_tests++;
        if (word_ready !== 1'b1 || busy !== 1'b1 || bit_count !== '0) begin
            n_fail++;
            $display("FAIL load_entry: ready=%b busy=%b count=%0d, want 1 1 0",
                     word_ready, busy, bit_count);
        end
        word_in = words[0]; word_valid = 1'b1;
        prev_ready = word_ready; prev_valid = 1'b1;
        @(negedge cclk);
        n_tests++;
        if (cfg_en !== 1'b1 || word_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL first_shift_latency: cfg_en=%b ready=%b, want 1 0", cfg_en, word_ready);
        end
        feed_until(0, -1, 400);
        n_tests++;
        if (stream.size() != CHAIN_LEN) begin
            n_fail++;
            $display("FAIL full_bit_total: got %0d cfg_en cycles, want %0d", stream.size(), CHAIN_LEN);
        end
        n_tests++;
        if (stream_errors() != 0) begin
            n_fail++;
            $display("FAIL full_stream: %0d wrong bits, want 0", stream_errors());
        end
        n_tests++;
        if (idx != N_WORDS) begin
            n_fail++;
            $display("FAIL full_words_taken: got %0d, want %0d", idx, N_WORDS);
        end
        n_tests++;
        if (elapsed != (N_WORDS - 1) * (WORD_W + 1) + LAST_BITS) begin
            n_fail++;
            $display("FAIL full_rate: got %0d cycles, want %0d", elapsed,
                     (N_WORDS - 1) * (WORD_W + 1) + LAST_BITS);
        end
        repeat (4) @(negedge cclk);
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || cfg_en !== 1'b0 || word_ready !== 1'b0 ||
            bit_count !== CNT_W'(CHAIN_LEN) || stream.size() != CHAIN_LEN) begin
            n_fail++;
            $display("FAIL done_hold: done=%b busy=%b en=%b rdy=%b count=%0d bits=%0d, want 1 0 0 0 %0d %0d",
                     done, busy, cfg_en, word_ready, bit_count, stream.size(), CHAIN_LEN, CHAIN_LEN);
        end
    endtask

    task automatic test_stalled_host();
        do_start();
        feed_until(10, -1, 800);
        n_tests++;
        if (stream.size() != CHAIN_LEN || stream_errors() != 0) begin
            n_fail++;
            $display("FAIL stall_stream: bits=%0d errors=%0d, want %0d 0",
                     stream.size(), stream_errors(), CHAIN_LEN);
        end
        n_tests++;
        if (gap_bad != 0 || load_cycles != N_WORDS * 11) begin
            n_fail++;
            $display("FAIL stall_gaps: bad gaps=%0d load cycles=%0d, want 0 %0d",
                     gap_bad, load_cycles, N_WORDS * 11);
        end
        n_tests++;
        if (done !== 1'b1 || bit_count !== CNT_W'(CHAIN_LEN)) begin
            n_fail++;
            $display("FAIL stall_done: done=%b count=%0d, want 1 %0d", done, bit_count, CHAIN_LEN);
        end
    endtask

    task automatic test_abort();
        do_start();
        feed_until(0, 40, 400);
        abort = 1'b1;
        @(negedge cclk);
        abort = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || cfg_en !== 1'b0 || done !== 1'b0 || bit_count !== CNT_W'(40)) begin
            n_fail++;
            $display("FAIL abort_shift: busy=%b en=%b done=%b count=%0d, want 0 0 0 40",
                     busy, cfg_en, done, bit_count);
        end
        repeat (3) @(negedge cclk);
        n_tests++;
        if (word_ready !== 1'b0 || done !== 1'b0 || bit_count !== CNT_W'(40)) begin
            n_fail++;
            $display("FAIL abort_idle_hold: rdy=%b done=%b count=%0d, want 0 0 40",
                     word_ready, done, bit_count);
        end
        do_start();
        n_tests++;
        if (bit_count !== '0 || word_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_after_abort: count=%0d rdy=%b, want 0 1", bit_count, word_ready);
        end
        abort = 1'b1; word_valid = 1'b1; word_in = words[0];
        @(negedge cclk);
        abort = 1'b0; word_valid = 1'b0;
        @(negedge cclk);
        n_tests++;
        if (busy !== 1'b0 || cfg_en !== 1'b0 || stream.size() != 0) begin
            n_fail++;
            $display("FAIL abort_over_handshake: busy=%b en=%b bits=%0d, want 0 0 0",
                     busy, cfg_en, stream.size());
        end
    endtask

    task automatic test_reset_mid_shift();
        do_start();
        feed_until(0, 70, 400);
        rst = 1'b1;
        @(negedge cclk);
        n_tests++;
        if ({word_ready, cfg_en, cfg_bit, busy, done} !== 5'b0 || bit_count !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_shift: flags=%b count=%0d, want 0",
                     {word_ready, cfg_en, cfg_bit, busy, done}, bit_count);
        end
        rst = 1'b0;
        do_start();
        feed_until(0, -1, 400);
        n_tests++;
        if (stream.size() != CHAIN_LEN || stream_errors() != 0 ||
            bit_count !== CNT_W'(CHAIN_LEN)) begin
            n_fail++;
            $display("FAIL reload_after_reset: bits=%0d errors=%0d count=%0d, want %0d 0 %0d",
                     stream.size(), stream_errors(), bit_count, CHAIN_LEN, CHAIN_LEN);
        end
    endtask

    task automatic test_start_ignored();
        do_start();
        feed_until(0, 20, 400);
        start = 1'b1;
        @(negedge cclk);
        start = 1'b0;
        n_tests++;
        if (bit_count !== CNT_W'(21) || cfg_en !== 1'b1) begin
            n_fail++;
            $display("FAIL start_in_shift: count=%0d en=%b, want 21 1", bit_count, cfg_en);
        end
        feed_until(0, WORD_W - 1, 400);
        @(negedge cclk);
        start = 1'b1;
        @(negedge cclk);
        start = 1'b0;
        n_tests++;
        if (word_ready !== 1'b1 || busy !== 1'b1 || bit_count !== CNT_W'(WORD_W)) begin
            n_fail++;
            $display("FAIL start_in_load: rdy=%b busy=%b count=%0d, want 1 1 %0d",
                     word_ready, busy, bit_count, WORD_W);
        end
        feed_until(0, -1, 400);
        n_tests++;
        if (stream.size() != CHAIN_LEN || stream_errors() != 0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL ignored_start_stream: bits=%0d errors=%0d done=%b, want %0d 0 1",
                     stream.size(), stream_errors(), done, CHAIN_LEN);
        end
        start = 1'b1;
        @(negedge cclk);
        start = 1'b0;
        n_tests++;
        if (done !== 1'b0 || bit_count !== '0 || busy !== 1'b1 || word_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_from_done: done=%b count=%0d busy=%b rdy=%b, want 0 0 1 1",
                     done, bit_count, busy, word_ready);
        end
        abort = 1'b1;
        @(negedge cclk);
        abort = 1'b0;
        do_start();
        feed_until(0, -1, 400);
        abort = 1'b1; start = 1'b1;
        @(negedge cclk);
        abort = 1'b0; start = 1'b0;
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || word_ready !== 1'b0 || cfg_en !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_over_start_in_done: done=%b busy=%b rdy=%b en=%b, want 0 0 0 0",
                     done, busy, word_ready, cfg_en);
        end
    endtask

    task automatic test_param_sweep();
        logic [WORD_W2-1:0] w2[$];
        int   idx2 = 0, tail = 0, nbits = 0, mism = 0, cyc = 0;
        logic pr = 1'b0, pv = 1'b0;
        for (int i = 0; i < N_WORDS2 + 1; i++) w2.push_back(WORD_W2'($urandom));
        @(negedge cclk);
        s_start = 1'b1;
        @(negedge cclk);
        s_start = 1'b0;
        while (s_done !== 1'b1 && cyc < 400) begin
            if (pr && pv) begin
                idx2++;
                tail = 0;
            end
            if (s_cfg_en === 1'b1) begin
                if (nbits < CHAIN2 && s_cfg_bit !== w2[nbits / WORD_W2][nbits % WORD_W2]) mism++;
                nbits++;
                tail++;
            end
            s_word_valid = (idx2 < w2.size());
            if (idx2 < w2.size()) s_word_in = w2[idx2];
            pr = s_word_ready;
            pv = s_word_valid;
            @(negedge cclk);
            cyc++;
        end
        s_word_valid = 1'b0;
        n_tests++;
        if (s_done !== 1'b1 || s_bit_count !== CNT2_W'(CHAIN2) || cyc != (N_WORDS2 - 1) * (WORD_W2 + 1) + LAST_BITS2 + 1) begin
            n_fail++;
            $display("FAIL sweep_done: done=%b count=%0d cycles=%0d, want 1 %0d %0d",
                     s_done, s_bit_count, cyc, CHAIN2, (N_WORDS2 - 1) * (WORD_W2 + 1) + LAST_BITS2 + 1);
        end
        n_tests++;
        if (nbits != CHAIN2 || mism != 0) begin
            n_fail++;
            $display("FAIL sweep_stream: bits=%0d errors=%0d, want %0d 0", nbits, mism, CHAIN2);
        end
        n_tests++;
        if (idx2 != N_WORDS2 || tail != LAST_BITS2) begin
            n_fail++;
            $display("FAIL sweep_last_word: words=%0d last bits=%0d, want %0d %0d",
                     idx2, tail, N_WORDS2, LAST_BITS2);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_load();
        test_stalled_host();
        test_abort();
        test_reset_mid_shift();
        test_start_ignored();
        test_param_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/slice_config_loader.md
SLICE_CONFIG_LOADER -- requirements
Module: slice_config_loader

Interface
REQ-001 Parameter S_XX_BASE, default 4, LUT input base; CFG_SIZE = 2**S_XX_BASE+1 (17).
REQ-002 Parameter NUM_LUTS, default 4, LUTs per slice.
REQ-003 Parameter WORD_W, default 32, host word width.
REQ-004 Derived constant CHAIN_LEN = NUM_LUTS*2*CFG_SIZE+1 (137 at defaults), total slice config bits including the carry-chain enable bit.
REQ-005 cclk  input  1  configuration clock; the only clock.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  single-cycle request to begin a configuration load.
REQ-008 abort  input  1  cancels a load in progress.
REQ-009 word_in  input  WORD_W  host configuration word, LSB shifted first.
REQ-010 word_valid  input  1  word_in valid.
REQ-011 word_ready  output  1  loader accepts word_in this cycle.
REQ-012 cfg_bit  output  1  serial config data to the slice chain.
REQ-013 cfg_en  output  1  config shift enable (drives slice cen).
REQ-014 busy  output  1  load in progress.
REQ-015 done  output  1  full CHAIN_LEN bits delivered.
REQ-016 bit_count  output  $clog2(CHAIN_LEN+1)  bits shifted in the current load.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, SHIFT, DONE; all outputs SHALL be decoded from registered state/datapath only.
REQ-018 IDLE: word_ready=0, cfg_en=0, busy=0, done=0; start -> LOAD with bit_count cleared.
REQ-019 LOAD: word_ready=1, cfg_en=0, busy=1; on word_valid&word_ready, capture word_in into the shift register, set word_left = min(WORD_W, CHAIN_LEN-bit_count), go to SHIFT.
REQ-020 SHIFT: word_ready=0, cfg_en=1, cfg_bit = shift register bit 0; each cycle shift right by 1, increment bit_count, decrement word_left.
REQ-021 SHIFT exit: when bit_count reaches CHAIN_LEN -> DONE; else when word_left reaches 0 -> LOAD.
REQ-022 Latency: first cfg_en=1 cycle SHALL be the cycle after the accepting handshake; one word every WORD_W+1 cycles maximum.
REQ-023 Final word: only CHAIN_LEN mod WORD_W (9 at defaults) LSBs SHALL be shifted; remaining bits discarded.
REQ-024 DONE: done=1, busy=0, cfg_en=0, word_ready=0, bit_count held at CHAIN_LEN; start -> LOAD (restart, bit_count cleared, done cleared).
REQ-025 start while in LOAD or SHIFT SHALL be ignored.
REQ-026 abort in LOAD, SHIFT or DONE SHALL move to IDLE next cycle; cfg_en=0 from that cycle; done not asserted; abort has priority over a simultaneous handshake or start.
REQ-027 word_valid while word_ready=0 SHALL have no effect; host holds word_in stable until accepted.
REQ-028 bit_count SHALL never exceed CHAIN_LEN.

Reset
REQ-029 rst SHALL force IDLE, bit_count=0, word_left=0, shift register=0, so all outputs are 0 the cycle after rst is sampled high.
REQ-030 rst SHALL override start, abort and handshake; reset mid-load SHALL leave the slice chain partially loaded with cfg_en=0.

Structure
REQ-031 CHAIN_LEN derivation, CFG_SIZE and the FSM state enum SHALL live in a shared package, clb_cfg_pkg.
REQ-032 The block SHALL be a single module plus one sub-module, cfg_piso (WORD_W-bit parallel-in serial-out shift register with load/shift enables).

Verification
REQ-033 Full load: start, host supplies 5 words back-to-back -> exactly 137 cfg_en=1 cycles, done=1, cfg_bit stream equals concatenated words LSB-first truncated to 137 bits.
REQ-034 Stalled host: word_valid low 10 cycles in each LOAD -> cfg_en gaps only in LOAD, bit stream unchanged, bit_count=137 at done.
REQ-035 Abort after 40 bits -> IDLE next cycle, cfg_en=0, done=0, bit_count reset only on next start.
REQ-036 Reset mid-SHIFT (bit_count=70) -> all outputs 0 next cycle; subsequent start loads 137 bits correctly.
REQ-037 start during SHIFT ignored, bit_count continues; start in DONE restarts with bit_count=0, done=0.
REQ-038 Parameter sweep NUM_LUTS=2, WORD_W=8 -> CHAIN_LEN=69, 9 words, last word shifts 5 bits.
